mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle MIPS core between two requesters.
- Port C is the core datapath, used for instruction fetch and load/store.
- Port D is a DMA/program-loader requester.
- Sequences each access as a registered multi-cycle transaction against a variable-latency memory (ready handshake). Returns a one-cycle ack so the core controller can hold its state while waiting.

Parameters:
CORE_PRIORITY, 0, 0 = strict round-robin; 1 = port C preferred, with a burst limit
MAX_BURST, 4, max consecutive C grants while d_req is pending (used only when CORE_PRIORITY=1); range 1..15
TIMEOUT, 16, BUSY cycles without mem_ready before abort (used only with ARB_TIMEOUT_EN); range 1..255

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset
c_req  in  1  port C request; held until c_ack
c_r_wbar  in  1  port C 1 = read, 0 = write
c_addr  in  32  port C byte address
c_wdata  in  32  port C write data
c_rdata  out  32  port C read data, registered
c_ack  out  1  port C completion, one-cycle pulse
d_req  in  1  port D request
d_r_wbar  in  1  port D 1 = read, 0 = write
d_addr  in  32  port D byte address
d_wdata  in  32  port D write data
d_rdata  out  32  port D read data, registered
d_ack  out  1  port D completion, one-cycle pulse
mem_req  out  1  memory access strobe, held until mem_ready
mem_r_wbar  out  1  memory read (1) / write (0)
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid with mem_ready
mem_ready  in  1  memory completion
grant  out  2  one-hot owner of the current transaction: bit0 = C, bit1 = D
err  out  1  sticky timeout flag

Behaviour:
- Reset state, all registered outputs:
  - state = IDLE; mem_req = 0; mem_r_wbar = 1; mem_addr, mem_wdata, c_rdata, d_rdata = 0.
  - c_ack = d_ack = 0; grant = 2'b00; err = 0.
  - last_owner = D, so C wins the first tie; burst_cnt = 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Samples c_req and d_req at each edge; neither high → stay in IDLE.
  - Exactly one high → grant it.
  - Both high, CORE_PRIORITY=0 → grant the port that is not last_owner.
  - Both high, CORE_PRIORITY=1 → grant C unless burst_cnt == MAX_BURST, then grant D.
  - On grant, the same edge:
    - latch the owner's r_wbar/addr/wdata into mem_r_wbar/mem_addr/mem_wdata;
    - set mem_req = 1 and set grant;
    - update last_owner;
    - go to BUSY.
- burst_cnt:
  - Increments on a C grant made while d_req is high; saturates at MAX_BURST.
  - Clears on any D grant, and on any grant made while d_req is low.
- BUSY:
  - mem_req, mem_r_wbar, mem_addr, mem_wdata held constant.
  - Requester inputs are ignored; changes after the grant have no effect.
  - On the edge where mem_ready = 1:
    - for a read, capture mem_rdata into the owner's rdata register;
    - for a write, both rdata registers are left unchanged;
    - mem_req → 0, owner's ack → 1, go to DONE.
- DONE:
  - Lasts one cycle; ack is high exactly this cycle.
  - Requests are not sampled.
  - Next edge: ack → 0, grant → 00, go to IDLE.
- Latency:
  - Request high before edge 1 → mem_req high after edge 1.
  - With mem_ready high on the first BUSY cycle, ack is high after edge 2.
  - Minimum 3 cycles per transaction; back-to-back grants are every 3 cycles.
- rdata holds its value until the next completed read on that port.
- Requester drops req during BUSY → the transaction still completes and ack still pulses.
- mem_ready high while not in BUSY → ignored.
- Reset asserted in any state → all outputs return to reset values immediately (asynchronous). Any in-flight transaction is abandoned with no ack.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT without mem_ready: go to DONE, pulse the owner's ack, leave rdata unchanged, set err = 1.
  - err is sticky until reset.
- Undefined:
  - BUSY waits indefinitely for mem_ready.
  - err is tied to 0; the counter is not built.

Test Plan:
- Core read: c_req, c_r_wbar=1, c_addr=0x0000_0040; memory asserts mem_ready 2 cycles after mem_req with mem_rdata=0x1234_5678 -> mem_req high 2 cycles with mem_addr=0x40; grant=01; c_ack single pulse; c_rdata=0x1234_5678; d_ack never high.
- DMA write: d_req, d_r_wbar=0, d_addr=0x100, d_wdata=0xA5A5_A5A5; mem_ready immediate -> mem_r_wbar=0, mem_wdata stable while mem_req=1, d_ack 1 cycle, d_rdata unchanged (0).
- CORE_PRIORITY=0, both requesting continuously from reset -> grant sequence C, D, C, D; one transaction per 3 cycles with zero-wait memory.
- CORE_PRIORITY=1, MAX_BURST=4, both continuously -> grant pattern C, C, C, C, D, repeating; d_ack every 5th completion.
- reset driven low two cycles into BUSY (mem_ready low) -> mem_req, grant, acks, err go to 0 the same cycle without a clock edge; after release, state is IDLE and a fresh C request completes normally.
- With ARB_TIMEOUT_EN, TIMEOUT=16, mem_ready held low -> c_ack pulses after 16 BUSY cycles; err=1 and stays 1 through later successful transactions until reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory between the core datapath
// (port C) and a DMA/program-loader (port D). Each access runs as a
// registered IDLE -> BUSY -> DONE transaction against a ready-handshaked
// memory; the owner receives a one-cycle ack in DONE.
// Optional build macro: ARB_TIMEOUT_EN (abort a BUSY access after TIMEOUT
// cycles without mem_ready and raise a sticky err).
module mem_port_arbiter #(
    parameter int CORE_PRIORITY = 0,
    parameter int MAX_BURST     = 4,
    parameter int TIMEOUT       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic        c_r_wbar,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic [31:0] c_rdata,
    output logic        c_ack,
    input  logic        d_req,
    input  logic        d_r_wbar,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_req,
    output logic        mem_r_wbar,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [1:0]  grant,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, next_state;
    logic        last_d;      // 1 = D owned the previous transaction
    logic [3:0]  burst_cnt;   // consecutive C grants made while D waited
    logic        pick_c, pick_d;
    logic        finish;      // BUSY ends this edge (ready or timeout)
    logic        abort;       // BUSY ends by timeout

`ifdef ARB_TIMEOUT_EN
    logic [7:0]  tmo_cnt;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Arbitration decision and next-state logic
    always_comb begin
        next_state = state;
        pick_c     = 1'b0;
        pick_d     = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        unique case (state)
            IDLE: begin
                if (c_req && d_req) begin
                    if (CORE_PRIORITY != 0) pick_c = (burst_cnt != 4'(MAX_BURST));
                    else                    pick_c = last_d;
                    pick_d = !pick_c;
                end else begin
                    pick_c = c_req;
                    pick_d = d_req;
                end
                if (pick_c || pick_d) next_state = BUSY;
            end
            BUSY: begin
                if (mem_ready) begin
                    finish = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
                    // tmo_cnt counts BUSY cycles already elapsed, so this is
                    // the TIMEOUT-th BUSY cycle without mem_ready
                    finish = 1'b1;
                    abort  = 1'b1;
                end
`endif
                if (finish) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Transaction registers: memory strobe/address/data, grant, acks, rdata
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req    <= 1'b0;
            mem_r_wbar <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            c_rdata    <= '0;
            d_rdata    <= '0;
            c_ack      <= 1'b0;
            d_ack      <= 1'b0;
            grant      <= 2'b00;
            last_d     <= 1'b1;
            burst_cnt  <= '0;
        end else begin
            c_ack <= 1'b0;
            d_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_c || pick_d) begin
                        mem_req    <= 1'b1;
                        grant      <= {pick_d, pick_c};
                        last_d     <= pick_d;
                        mem_r_wbar <= pick_c ? c_r_wbar : d_r_wbar;
                        mem_addr   <= pick_c ? c_addr   : d_addr;
                        mem_wdata  <= pick_c ? c_wdata  : d_wdata;
                        if (pick_d || !d_req)
                            burst_cnt <= '0;
                        else if (burst_cnt != 4'(MAX_BURST))
                            burst_cnt <= burst_cnt + 4'd1;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        mem_req <= 1'b0;
                        c_ack   <= grant[0];
                        d_ack   <= grant[1];
                        if (!abort && mem_r_wbar) begin
                            if (grant[0]) c_rdata <= mem_rdata;
                            if (grant[1]) d_rdata <= mem_rdata;
                        end
                    end
                end
                DONE:    grant <= 2'b00;
                default: grant <= 2'b00;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    // BUSY cycle counter and sticky timeout flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (state != BUSY)  tmo_cnt <= '0;
            else if (!finish)   tmo_cnt <= tmo_cnt + 8'd1;
            if (abort)          err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
